// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: state encodings, default
// widths, memory depth and fixed requester slots.
package mem_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_MAX_BURST  = 8;
    localparam int DEF_MEM_DEPTH  = 1024;

    // Burst counter width; holds MAX_BURST-1 for MAX_BURST up to 255.
    localparam int BURST_CW = 8;

    localparam int REQ_REWARD  = 0;
    localparam int REQ_QUPDATE = 1;
    localparam int REQ_ACTION  = 2;
    localparam int REQ_NBR     = 3;

    // Pointer to the requester after g, wrapping modulo n.
    function automatic int rr_next(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// Ports: i_req (request vector), i_ptr (start index), o_gnt (one-hot
// winner), o_idx (winner index), o_valid (any request present).
module rr_pick
    import mem_arbiter_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [IW-1:0] w_c;

    // Scan from i_ptr upward, wrapping; first request found wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_c     = '0;
        for (int k = 0; k < N; k++) begin
            w_c = IW'((int'(i_ptr) + k) % N);
            if (!o_valid && i_req[w_c]) begin
                o_valid    = 1'b1;
                o_gnt[w_c] = 1'b1;
                o_idx      = w_c;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin, burst-limited arbiter sharing one single-port
// memory between NUM_REQ requesters, with one-cycle read latency.
// Ports: clock/reset (sync, active-high); req/req_we/req_addr/req_wdata
// (packed per requester); gnt (registered one-hot), rvalid, rdata, busy;
// mem_addr/mem_wr_en/mem_data_in/mem_data_out to the memory; err.
// Optional: define MEM_ARB_ADDR_CHECK_EN to suppress accesses at or above
// MEM_DEPTH and pulse err; otherwise err is tied low.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          busy,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_wr_en,
    output logic [DATA_WIDTH-1:0]         mem_data_in,
    input  logic [DATA_WIDTH-1:0]         mem_data_out,
    output logic                          err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [BURST_CW-1:0] LAST_BEAT = BURST_CW'(MAX_BURST - 1);

    arb_state_t            r_state;
    logic [NUM_REQ-1:0]    r_gnt;
    logic [NUM_REQ-1:0]    r_rvalid;
    logic [IW-1:0]         r_gidx;
    logic [IW-1:0]         r_rr_ptr;
    logic [BURST_CW-1:0]   r_burst_cnt;
    logic                  r_rd_zero;
    logic                  r_err;

    logic [NUM_REQ-1:0]    w_pick_gnt;
    logic [IW-1:0]         w_pick_idx;
    logic                  w_pick_valid;
    logic                  w_active;
    logic                  w_access;
    logic                  w_we;
    logic                  w_last;
    logic                  w_oob;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [IW-1:0]         w_next_ptr;

    logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_active    = |r_gnt;
    assign w_access    = w_active & req[r_gidx];
    assign w_we        = req_we[r_gidx];
    assign w_sel_addr  = w_addr_arr[r_gidx];
    assign w_sel_wdata = w_wdata_arr[r_gidx];
    assign w_last      = (r_burst_cnt == LAST_BEAT);
    assign w_next_ptr  = IW'(rr_next(int'(r_gidx), NUM_REQ));

`ifdef MEM_ARB_ADDR_CHECK_EN
    assign w_oob = w_active &
                   ({1'b0, w_sel_addr} >= (ADDR_WIDTH+1)'(MEM_DEPTH));
`else
    assign w_oob = 1'b0;
`endif

    // Memory bus is driven only while a grant is held; zero otherwise.
    assign mem_addr    = w_active ? w_sel_addr  : '0;
    assign mem_data_in = w_active ? w_sel_wdata : '0;
    assign mem_wr_en   = w_access & w_we & ~w_oob;

    assign gnt    = r_gnt;
    assign busy   = w_active;
    assign rvalid = r_rvalid;
    assign err    = r_err;
    // Suppressed out-of-range reads return zero.
    assign rdata  = (|r_rvalid && !r_rd_zero) ? mem_data_out : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_gidx      <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_rvalid    <= '0;
            r_rd_zero   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_rvalid  <= '0;
            r_rd_zero <= 1'b0;
            r_err     <= w_access & w_oob;
            if (w_access && !w_we) begin
                r_rvalid  <= r_gnt;
                r_rd_zero <= w_oob;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_gnt       <= w_pick_gnt;
                        r_gidx      <= w_pick_idx;
                        r_burst_cnt <= '0;
                        r_state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Release on a dropped request or the last beat.
                    if (!w_access || w_last) begin
                        r_gnt    <= '0;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
